// File: rtl/inequality_range_gen_if.sv
// Handshake bundle for inequality_range_gen.
//   req_valid/req_ready/req_class : request channel (requester -> generator)
//   num_valid/num_ready/num       : value stream (generator -> consumer)
//   done/count                    : end-of-scan pulse and beat count of the last scan
// modport master: requester/consumer side; modport slave: the generator.
interface inequality_range_gen_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_class;
    logic             num_valid;
    logic             num_ready;
    logic [WIDTH-1:0] num;
    logic             done;
    logic [WIDTH:0]   count;

    modport master (
        output req_valid, req_class, num_ready,
        input  req_ready, num_valid, num, done, count
    );

    modport slave (
        input  req_valid, req_class, num_ready,
        output req_ready, num_valid, num, done, count
    );
endinterface

// File: rtl/inequality_range_gen.sv
// Enumerates, in ascending order, every WIDTH-bit value whose {GT, EQ, LT} class relative
// to THRESH is selected by the request mask, then pulses done with the beat count.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave side of inequality_range_gen_if (request, value stream, done/count)
module inequality_range_gen #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned THRESH = 8
) (
    input logic                  clk,
    input logic                  reset,
    inequality_range_gen_if.slave bus
);
    localparam logic [WIDTH-1:0] THRESH_W   = WIDTH'(THRESH);
    localparam logic [WIDTH-1:0] CURSOR_MAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cursor_q, cursor_d;
    logic [2:0]       class_q, class_d;
    logic [WIDTH:0]   beats_q, beats_d;
    logic [WIDTH:0]   count_q, count_d;
    logic             match;
    logic             advance;

    // Registered-only decode: num_valid never depends on num_ready.
    assign match = (class_q[2] & (cursor_q > THRESH_W))  |
                   (class_q[1] & (cursor_q == THRESH_W)) |
                   (class_q[0] & (cursor_q < THRESH_W));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cursor_q <= '0;
            class_q  <= '0;
            beats_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            class_q  <= class_d;
            beats_q  <= beats_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        class_d       = class_q;
        beats_d       = beats_q;
        count_d       = count_q;
        advance       = 1'b0;
        bus.req_ready = 1'b0;
        bus.num_valid = 1'b0;
        bus.done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    class_d  = bus.req_class;
                    cursor_d = '0;
                    beats_d  = '0;
                    state_d  = StScan;
                end
            end
            StScan: begin
                bus.num_valid = match;
                // Non-matching values cost one cycle; matching ones wait for the handshake.
                advance = ~match | bus.num_ready;
                if (match && bus.num_ready) begin
                    beats_d = beats_q + 1'b1;
                end
                if (advance) begin
                    if (cursor_q == CURSOR_MAX) begin
                        state_d = StDone;
                        count_d = beats_d;
                    end else begin
                        cursor_d = cursor_q + 1'b1;
                    end
                end
            end
            StDone: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.num   = cursor_q;
    assign bus.count = count_q;

endmodule

// File: tb/tb_inequality_range_gen.sv
module tb_inequality_range_gen;
    logic clk;
    logic reset;

    inequality_range_gen_if #(.WIDTH(4)) bus ();

    inequality_range_gen #(
        .WIDTH (4),
        .THRESH(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  cls;
        logic [15:0] mask;
        int          cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int next_in(input logic [15:0] mask, input int from);
        for (int v = from; v < 16; v++) begin
            if (mask[v]) return v;
        end
        return 16;
    endfunction

    // Present a request at the next falling edge; return just after the accepting edge.
    task automatic issue(input logic [2:0] cls, input string name);
        @(negedge clk);
        chk($sformatf("%s req_ready idle", name), 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_class = cls;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_class = ~cls;  // must not matter once latched
    endtask

    // Follow one scan from just after the accept edge through the first IDLE cycle.
    task automatic collect(input logic [15:0] mask, input int exp_cnt, input int exp_done,
                           input logic [15:0] stall_vals, input int stall_len,
                           input string name);
        int          cyc;
        int          beats;
        int          nxt;
        int          stall_left;
        logic [3:0]  stall_num;
        logic [15:0] served;
        logic        got_done;
        cyc        = 0;
        beats      = 0;
        nxt        = next_in(mask, 0);
        stall_left = 0;
        stall_num  = '0;
        served     = '0;
        got_done   = 1'b0;
        while (!got_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                got_done = 1'b1;
                chk($sformatf("%s done cycle", name), cyc, exp_done);
                chk($sformatf("%s count", name), 32'(bus.count), exp_cnt);
                chk($sformatf("%s beats", name), beats, exp_cnt);
                chk($sformatf("%s valid in done", name), 32'(bus.num_valid), 0);
            end else if (bus.num_valid) begin
                if (stall_left == 0 && stall_vals[bus.num] && !served[bus.num]) begin
                    served[bus.num] = 1'b1;
                    stall_num       = bus.num;
                    stall_left      = stall_len;
                    bus.num_ready   = 1'b0;
                    stall_left--;
                end else if (stall_left > 0) begin
                    chk($sformatf("%s held num", name), 32'(bus.num), 32'(stall_num));
                    bus.num_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.num_ready = 1'b1;
                    chk($sformatf("%s beat %0d", name, beats), 32'(bus.num), nxt);
                    beats++;
                    nxt = next_in(mask, nxt + 1);
                end
            end else begin
                bus.num_ready = 1'b1;
            end
        end
        chk($sformatf("%s done seen", name), 32'(got_done), 1);
        bus.num_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("%s req_ready after", name), 32'(bus.req_ready), 1);
        chk($sformatf("%s done low after", name), 32'(bus.done), 0);
        chk($sformatf("%s count holds", name), 32'(bus.count), exp_cnt);
    endtask

    initial begin
        int   cyc;
        logic busy_bad;
        logic found;

        vecs[0] = '{cls: 3'b010, mask: 16'h0100, cnt: 1};
        vecs[1] = '{cls: 3'b100, mask: 16'hFE00, cnt: 7};
        vecs[2] = '{cls: 3'b001, mask: 16'h00FF, cnt: 8};
        vecs[3] = '{cls: 3'b111, mask: 16'hFFFF, cnt: 16};
        vecs[4] = '{cls: 3'b000, mask: 16'h0000, cnt: 0};
        vecs[5] = '{cls: 3'b101, mask: 16'hFEFF, cnt: 15};
        vecs[6] = '{cls: 3'b110, mask: 16'hFF00, cnt: 8};
        vecs[7] = '{cls: 3'b011, mask: 16'h01FF, cnt: 9};

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_class = 3'b000;
        bus.num_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("reset req_ready", 32'(bus.req_ready), 1);
        chk("reset num_valid", 32'(bus.num_valid), 0);
        chk("reset done", 32'(bus.done), 0);
        chk("reset count", 32'(bus.count), 0);
        chk("reset num", 32'(bus.num), 0);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].cls, $sformatf("vec%0d", i));
            collect(vecs[i].mask, vecs[i].cnt, 17, 16'h0000, 0, $sformatf("vec%0d", i));
        end

        // LT with 3-cycle stalls at num=2 and num=5: done slips by 6 cycles.
        issue(3'b001, "lt_stall");
        collect(16'h00FF, 8, 23, 16'h0024, 3, "lt_stall");

        // Request held high through a scan; the second request re-latches a new class.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_class = 3'b010;
        @(posedge clk);
        #1;
        busy_bad = 1'b0;
        cyc      = 0;
        while (cyc < 17) begin
            @(negedge clk);
            cyc++;
            if (bus.req_ready) busy_bad = 1'b1;
            if (cyc == 17) begin
                chk("hold done pulse", 32'(bus.done), 1);
                chk("hold first count", 32'(bus.count), 1);
                bus.req_class = 3'b100;
            end
        end
        chk("hold req_ready low in scan/done", 32'(busy_bad), 0);
        @(negedge clk);
        chk("hold req_ready idle", 32'(bus.req_ready), 1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        collect(16'hFE00, 7, 17, 16'h0000, 0, "hold second");

        // Reset while num=3 is on offer.
        issue(3'b001, "rst");
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.num_valid && bus.num == 4'd3) found = 1'b1;
        end
        chk("rst reached num 3", 32'(found), 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst num_valid", 32'(bus.num_valid), 0);
        chk("rst done", 32'(bus.done), 0);
        chk("rst count", 32'(bus.count), 0);
        chk("rst req_ready", 32'(bus.req_ready), 1);
        issue(3'b010, "post_rst");
        collect(16'h0100, 1, 17, 16'h0000, 0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inequality_range_gen.md
Name: inequality_range_gen

Overview:
Sequential inverse of the combinational inequality classifier. The classifier maps a WIDTH-bit value to a 3-bit one-hot class {GT, EQ, LT} relative to THRESH. This block takes a class mask and streams every WIDTH-bit value belonging to that class, in ascending order, over a valid/ready handshake. It then reports completion and a beat count. It serves as a stimulus source and enumerator beside the classifier in the Standard Forms designs.

Parameters:
WIDTH, 4, bit width of enumerated values
THRESH, 8, comparison threshold (0 <= THRESH <= 2^WIDTH-1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_class  input  3  class mask: [2]=GT (v>THRESH), [1]=EQ (v==THRESH), [0]=LT (v<THRESH)
num_valid  output  1  num holds a value in the requested class
num_ready  input  1  consumer accepts num
num  output  WIDTH  enumerated value
done  output  1  one-cycle pulse at end of a scan
count  output  WIDTH+1  number of beats emitted in the last completed scan

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Every register updates only on the rising edge of clk.
- Reset values: state=IDLE, cursor=0, class register=0, count=0, done=0, num_valid=0, num=0. req_ready reads 1 in the first cycle after reset deasserts.
- States: IDLE, SCAN, DONE.
- IDLE:
  - req_ready=1, num_valid=0.
  - When req_valid is high, latch req_class, set cursor=0, clear the beat counter, and go to SCAN.
- SCAN:
  - req_ready=0. req_valid and req_class are ignored.
  - match = (class[2] & cursor>THRESH) | (class[1] & cursor==THRESH) | (class[0] & cursor<THRESH). Comparisons are unsigned, WIDTH bits.
  - num = cursor. num_valid = match. Both are decoded from registers only, with no combinational path from num_ready.
  - When match=1: hold cursor, num and num_valid stable until num_ready=1. On the handshake cycle, increment the beat counter and advance.
  - When match=0: advance in that cycle with no output beat. Each non-matching value costs exactly one cycle.
  - Advance: if cursor == 2^WIDTH-1, go to DONE. Otherwise cursor = cursor+1. The cursor never wraps.
  - With no stalls, SCAN lasts exactly 2^WIDTH cycles. Cursor value k is presented in the (k+1)th cycle after the accept edge.
- DONE:
  - Lasts exactly one cycle. done=1, count = beats emitted (0..2^WIDTH), num_valid=0.
  - Next state is IDLE.
  - count holds its value until the next scan completes or reset.
- req_class=000: a full scan runs with no beats, followed by done with count=0.
- req_class=111: every value is emitted (count=2^WIDTH, which needs the WIDTH+1-bit width).
- THRESH=0: the LT class is empty. THRESH=2^WIDTH-1: the GT class is empty. Both cases complete normally.
- Reset mid-operation: the scan is aborted. No done pulse, count=0, IDLE on the next cycle. A pending num beat is discarded.
- num_ready while num_valid=0 has no effect.

Test Plan:
All scenarios use WIDTH=4, THRESH=8.
- EQ only: req_class=010, num_ready=1. Exactly one beat, num=8, in cycle 9 after accept. done in cycle 17. count=1. req_ready=1 in cycle 18.
- GT only: req_class=100, num_ready=1. Beats 9,10,...,15 in order. done pulse. count=7.
- LT with backpressure: req_class=001, num_ready low for 3 cycles each time num=2 and num=5. num and num_valid are held stable during the stall. Beats 0..7. count=8. done is delayed by 6 cycles versus the no-stall case.
- Full and empty masks: req_class=111 gives beats 0..15 and count=16. Then req_class=000 gives no beats, done 17 cycles after accept, and count=0.
- Request during scan: with req_valid held high throughout, req_ready=0 in SCAN/DONE. A second request is accepted only in IDLE, and its class is re-latched.
- Reset mid-scan: reset asserted when num=3 (class 001). Next cycle num_valid=0, done=0, count=0, req_ready=1. A new request for 010 then completes normally with count=1.
